// File: rtl/char_cell_typer_pkg.sv
// Shared constants, FSM encoding and pixel helper for the character-cell typer.
// The package is named typer_pkg and is imported by every typer source file.
package typer_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;
  localparam int COLS    = 80;
  localparam int ROWS    = 60;
  localparam int CELLS   = 4800;
  localparam int IDX_W   = 13;
  localparam int ADDR_W  = 19;
  localparam int PIX_W   = 3;
  localparam int FADDR_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } typer_state_t;

  function automatic logic [PIX_W-1:0] pixel_colour(input logic             glyph_bit,
                                                    input logic [PIX_W-1:0] fg,
                                                    input logic [PIX_W-1:0] bg);
    return glyph_bit ? fg : bg;
  endfunction

endpackage

// File: rtl/char_cell_typer_if.sv
// Request, font-ROM and framebuffer-write bundle of the character-cell typer.
// master = sequencer/ROM/RAM side, slave = the typer itself.
interface char_cell_typer_if;
  import typer_pkg::*;

  logic                 start;
  logic [IDX_W-1:0]     cell_index;
  logic [7:0]           char_code;
  logic                 busy;
  logic                 done;
  logic [FADDR_W-1:0]   font_addr;
  logic [7:0]           font_row;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [PIX_W-1:0]     mem_wdata;
  logic                 mem_wenable;

  modport master (
    output start, cell_index, char_code, font_row,
    input  busy, done, font_addr, mem_waddr, mem_wdata, mem_wenable
  );

  modport slave (
    input  start, cell_index, char_code, font_row,
    output busy, done, font_addr, mem_waddr, mem_wdata, mem_wenable
  );

endinterface

// File: rtl/char_cell_typer_addr.sv
// Registered linear cell index -> top-left pixel address of the 8x8 cell.
// Division by 80 is done as (idx>>4)/5 with the reciprocal 205/1024, exact for idx < 8192.
module cell_to_pixel_addr
  import typer_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [IDX_W-1:0]  cell_index,
  output logic [ADDR_W-1:0] base_addr
);

  logic [8:0]        blk_s;
  logic [17:0]       prod_s;
  logic [6:0]        cell_row_s;
  logic [IDX_W-1:0]  row_x80_s;
  logic [IDX_W-1:0]  cell_col_s;
  logic [ADDR_W-1:0] base_d;
  logic [ADDR_W-1:0] base_q;

  // Row = idx/80, col = idx%80, base = row*5120 + col*8 using shifts and adds only.
  always_comb begin
    blk_s      = 9'(cell_index >> 4);
    prod_s     = ({9'd0, blk_s} << 7) + ({9'd0, blk_s} << 6) + ({9'd0, blk_s} << 3)
               + ({9'd0, blk_s} << 2) + {9'd0, blk_s};
    cell_row_s = 7'(prod_s >> 10);
    row_x80_s  = ({6'd0, cell_row_s} << 6) + ({6'd0, cell_row_s} << 4);
    cell_col_s = cell_index - row_x80_s;
    if (load) begin
      base_d = ({12'd0, cell_row_s} << 12) + ({12'd0, cell_row_s} << 10)
             + ({6'd0, cell_col_s} << 3);
    end else begin
      base_d = base_q;
    end
  end

  // Base address register, captured when a request is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q <= 19'd0;
    end else begin
      base_q <= base_d;
    end
  end

  assign base_addr = base_q;

endmodule

// File: rtl/char_cell_typer.sv
// Character-cell typer: renders one 8x8 glyph into a 640x480 3-bpp framebuffer.
// Define TYPER_TRANSPARENT_BG_EN to suppress writes of background (glyph bit 0) pixels.
module char_cell_typer
  import typer_pkg::*;
#(
  parameter int               SCREEN_W = 640,
  parameter int               SCREEN_H = 480,
  parameter logic [PIX_W-1:0] FG_COLOR = 3'b111,
  parameter logic [PIX_W-1:0] BG_COLOR = 3'b000
) (
  input logic              clock,
  input logic              reset_n,
  char_cell_typer_if.slave bus
);

  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(SCREEN_W);
  localparam logic [IDX_W-1:0]  CELL_LIMIT = IDX_W'((SCREEN_W / GLYPH_W) * (SCREEN_H / GLYPH_H));
`ifdef TYPER_TRANSPARENT_BG_EN
  localparam logic TRANSPARENT_BG = 1'b1;
`else
  localparam logic TRANSPARENT_BG = 1'b0;
`endif

  typer_state_t       state_q, state_d;
  logic [2:0]         row_q, row_d;
  logic [2:0]         col_q, col_d;
  logic [7:0]         char_q, char_d;
  logic [7:0]         shift_q, shift_d;
  logic [ADDR_W-1:0]  row_addr_q, row_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [FADDR_W-1:0] font_addr_q, font_addr_d;
  logic [ADDR_W-1:0]  mem_waddr_q, mem_waddr_d;
  logic [PIX_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic               mem_wenable_q, mem_wenable_d;
  logic               accept_s;
  logic               index_ok_s;
  logic [ADDR_W-1:0]  base_s;

  // The done cycle doubles as an idle cycle so back-to-back characters lose no time.
  assign accept_s   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;
  assign index_ok_s = (bus.cell_index < CELL_LIMIT);

  cell_to_pixel_addr u_addr (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (accept_s),
    .cell_index (bus.cell_index),
    .base_addr  (base_s)
  );

  // Next-state and next-output logic; each row is FETCH, LOAD, then eight WRITE cycles.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    char_d        = char_q;
    shift_d       = shift_q;
    row_addr_d    = row_addr_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    font_addr_d   = font_addr_q;
    mem_waddr_d   = mem_waddr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wenable_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          char_d = bus.char_code;
          row_d  = 3'd0;
          col_d  = 3'd0;
          if (index_ok_s) begin
            state_d     = ST_FETCH;
            busy_d      = 1'b1;
            font_addr_d = {bus.char_code, 3'd0};
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
        if (row_q == 3'd0) begin
          row_addr_d = base_s;
        end else begin
          row_addr_d = row_addr_q + ROW_STEP;
        end
      end
      ST_LOAD: begin
        state_d       = ST_WRITE;
        col_d         = 3'd0;
        shift_d       = {bus.font_row[6:0], 1'b0};
        mem_waddr_d   = row_addr_q;
        mem_wdata_d   = pixel_colour(bus.font_row[7], FG_COLOR, BG_COLOR);
        mem_wenable_d = bus.font_row[7] | ~TRANSPARENT_BG;
      end
      ST_WRITE: begin
        if (col_q != 3'd7) begin
          col_d         = col_q + 3'd1;
          shift_d       = {shift_q[6:0], 1'b0};
          mem_waddr_d   = row_addr_q + {16'd0, col_q + 3'd1};
          mem_wdata_d   = pixel_colour(shift_q[7], FG_COLOR, BG_COLOR);
          mem_wenable_d = shift_q[7] | ~TRANSPARENT_BG;
        end else if (row_q != 3'd7) begin
          row_d       = row_q + 3'd1;
          font_addr_d = {char_q, row_q + 3'd1};
          state_d     = ST_FETCH;
        end else begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      row_q         <= 3'd0;
      col_q         <= 3'd0;
      char_q        <= 8'd0;
      shift_q       <= 8'd0;
      row_addr_q    <= 19'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      font_addr_q   <= 11'd0;
      mem_waddr_q   <= 19'd0;
      mem_wdata_q   <= 3'd0;
      mem_wenable_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      char_q        <= char_d;
      shift_q       <= shift_d;
      row_addr_q    <= row_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      font_addr_q   <= font_addr_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wenable_q <= mem_wenable_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.font_addr   = font_addr_q;
  assign bus.mem_waddr   = mem_waddr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wenable = mem_wenable_q;

endmodule

// File: tb/tb_char_cell_typer.sv
// Bench for char_cell_typer: cycle-by-cycle comparison against a timeline model plus literal checks.
module tb_char_cell_typer;
  import typer_pkg::*;

`ifdef TYPER_TRANSPARENT_BG_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  char_cell_typer_if bus();

  char_cell_typer dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  int vec = 0;
  int errs = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  bit cmp_on = 1'b0;
  int rom_mode = 0;
  logic [7:0] rom_const = 8'h81;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom_fn(input logic [10:0] a, input int mode, input logic [7:0] k);
    logic [15:0] h;
    if (mode == 0) return k;
    h = {5'd0, a} * 16'd40503;
    return h[15:8] ^ h[7:0];
  endfunction

  // Font ROM: one-cycle registered read
  always @(posedge clock) bus.font_row <= rom_fn(bus.font_addr, rom_mode, rom_const);

  // Transaction timeline model: m_j = edges since the accepting edge
  logic        m_active = 1'b0;
  int          m_j = 0;
  logic        m_valid = 1'b0;
  logic [12:0] m_idx = 13'd0;
  logic [7:0]  m_chr = 8'd0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0;
    end else begin
      if (m_active && m_j < 1000) m_j = m_j + 1;
      if (bus.start && (!m_active || m_j >= (m_valid ? 81 : 1))) begin
        m_active = 1'b1;
        m_j      = 0;
        m_valid  = (bus.cell_index < 13'd4800);
        m_idx    = bus.cell_index;
        m_chr    = bus.char_code;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && bus.mem_wenable === 1'b1) wr_cnt++;
    if (reset_n && bus.done === 1'b1) done_cnt++;
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clock) begin : cmp_blk
    logic        e_busy, e_done, e_wen, e_fetch, e_bit;
    logic [18:0] e_addr;
    logic [2:0]  e_data;
    logic [10:0] e_fa;
    logic [7:0]  g;
    int          r, c;
    if (cmp_on) begin
      if (!reset_n) begin
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wen", bus.mem_wenable, 0);
        chk("rst_waddr", bus.mem_waddr, 0);
        chk("rst_fa", bus.font_addr, 0);
      end else begin
        e_busy = 0; e_done = 0; e_wen = 0; e_fetch = 0; e_bit = 0;
        e_addr = 0; e_data = 0; e_fa = 0;
        if (m_active) begin
          if (m_valid) begin
            e_busy = (m_j <= 79);
            e_done = (m_j == 80);
            if (m_j <= 79 && (m_j % 10) == 0) begin
              e_fetch = 1;
              e_fa    = {m_chr, 3'(m_j / 10)};
            end
            if (m_j >= 2 && m_j <= 79 && ((m_j - 2) % 10) < 8) begin
              r      = (m_j - 2) / 10;
              c      = (m_j - 2) % 10;
              g      = rom_fn({m_chr, 3'(r)}, rom_mode, rom_const);
              e_bit  = g[7 - c];
              e_wen  = TRANSP ? e_bit : 1'b1;
              e_addr = 19'((m_idx / 80) * 5120 + (m_idx % 80) * 8 + r * 640 + c);
              e_data = e_bit ? 3'b111 : 3'b000;
            end
          end else begin
            e_done = (m_j == 0);
          end
        end
        chk("busy", bus.busy, e_busy);
        chk("done", bus.done, e_done);
        chk("wen", bus.mem_wenable, e_wen);
        if (e_wen) begin
          chk("waddr", bus.mem_waddr, e_addr);
          chk("wdata", bus.mem_wdata, e_data);
        end
        if (e_fetch) chk("font_addr", bus.font_addr, e_fa);
      end
    end
  end

  task automatic go(input logic [12:0] idx, input logic [7:0] chr);
    bus.cell_index = idx;
    bus.char_code  = chr;
    bus.start      = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  function automatic int exp_writes(input logic [7:0] chr);
    int n;
    logic [7:0] g;
    n = 0;
    for (int r = 0; r < 8; r++) begin
      g = rom_fn({chr, 3'(r)}, rom_mode, rom_const);
      for (int c = 0; c < 8; c++) n += (TRANSP ? int'(g[c]) : 1);
    end
    return n;
  endfunction

  int w0, d0;

  initial begin
    bus.start = 1'b0; bus.cell_index = 13'd0; bus.char_code = 8'd0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_wen", bus.mem_wenable, 0);
    chk("reset_waddr", bus.mem_waddr, 0);
    chk("reset_wdata", bus.mem_wdata, 0);
    chk("reset_font_addr", bus.font_addr, 0);
    cmp_on  = 1'b1;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // 1: index 0, glyph rows 1000_0001
    rom_mode = 0; rom_const = 8'h81; w0 = wr_cnt;
    go(13'd0, 8'h41);
    chk("t1_busy_j0", bus.busy, 1);
    chk("t1_fa_j0", bus.font_addr, 11'h208);
    repeat (2) @(negedge clock);
    chk("t1_wen_c0", bus.mem_wenable, 1);
    chk("t1_addr_c0", bus.mem_waddr, 0);
    chk("t1_data_c0", bus.mem_wdata, 3'b111);
    @(negedge clock);
    chk("t1_addr_c1", bus.mem_waddr, 1);
    chk("t1_data_c1", bus.mem_wdata, 3'b000);
    chk("t1_wen_c1", bus.mem_wenable, TRANSP ? 0 : 1);
    repeat (6) @(negedge clock);
    chk("t1_addr_c7", bus.mem_waddr, 7);
    chk("t1_data_c7", bus.mem_wdata, 3'b111);
    repeat (63) @(negedge clock);
    chk("t1_addr_row7", bus.mem_waddr, 4480);
    repeat (8) @(negedge clock);
    chk("t1_done_j80", bus.done, 1);
    chk("t1_busy_j80", bus.busy, 0);
    @(negedge clock);
    chk("t1_done_j81", bus.done, 0);
    chk("t1_writes", wr_cnt - w0, TRANSP ? 16 : 64);

    // 2: index 81 -> base 5128
    rom_const = 8'h3C;
    go(13'd81, 8'h12);
    repeat (79) @(negedge clock);
    chk("t2_last_addr", bus.mem_waddr, 9615);
    @(negedge clock);
    chk("t2_done", bus.done, 1);
    @(negedge clock);

    // 3: last cell, font address sequence
    rom_mode = 1;
    go(13'd4799, 8'h7E);
    for (int r = 0; r < 8; r++) begin
      chk("t3_font_addr", bus.font_addr, 11'h3F0 + r);
      if (r < 7) repeat (10) @(negedge clock);
    end
    repeat (9) @(negedge clock);
    chk("t3_last_addr", bus.mem_waddr, 307199);
    repeat (2) @(negedge clock);

    // 4: start held while busy is ignored; then out-of-range index
    rom_mode = 0; rom_const = 8'hF0; w0 = wr_cnt;
    go(13'd1234, 8'h5A);
    for (int k = 0; k < 50; k++) begin
      bus.start      = 1'b1;
      bus.cell_index = 13'($urandom_range(0, 8191));
      bus.char_code  = 8'($urandom);
      @(negedge clock);
    end
    bus.start = 1'b0;
    repeat (32) @(negedge clock);
    chk("t4_writes", wr_cnt - w0, TRANSP ? 32 : 64);
    w0 = wr_cnt;
    go(13'd4800, 8'h20);
    chk("t4_bad_done", bus.done, 1);
    chk("t4_bad_busy", bus.busy, 0);
    @(negedge clock);
    chk("t4_bad_done_end", bus.done, 0);
    repeat (3) @(negedge clock);
    chk("t4_bad_writes", wr_cnt - w0, 0);

    // 5: reset mid-character aborts without done
    rom_mode = 1; d0 = done_cnt;
    go(13'd100, 8'h33);
    repeat (29) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_abort_busy", bus.busy, 0);
    chk("t5_abort_wen", bus.mem_wenable, 0);
    chk("t5_abort_waddr", bus.mem_waddr, 0);
    chk("t5_abort_fa", bus.font_addr, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (90) @(negedge clock);
    chk("t5_no_done", done_cnt - d0, 0);
    w0 = wr_cnt;
    go(13'd200, 8'h44);
    repeat (81) @(negedge clock);
    chk("t5_rerender_writes", wr_cnt - w0, exp_writes(8'h44));

    // Random traffic: starts at any time, some out-of-range indices
    rom_mode = 1;
    for (int k = 0; k < 4000; k++) begin
      bus.start      = ($urandom_range(0, 15) == 0);
      bus.cell_index = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(4800, 8191))
                                                   : 13'($urandom_range(0, 4799));
      bus.char_code  = 8'($urandom);
      @(negedge clock);
    end
    bus.start = 1'b0;
    repeat (100) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
